// File: rtl/fetch_stage_pkg.sv
// Shared RV32I fetch definitions: NOP encoding, fetch FSM states and the queued entry.
package fetch_stage_pkg;

   localparam logic [31:0] RV32I_NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_queue.sv
// Sync FIFO of fetch entries; head is combinational from storage (0-cycle read).
// Flush beats push and pop; a push while full is taken only alongside a pop.
module fetch_queue
   import fetch_stage_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             push_dat,
   output fetch_entry_t             head_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty && !flush;
   assign do_push  = push && !flush && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: owns the PC, credit-limited in-order IMEM requests, queue to decode.
// Request-to-id_valid latency is IMEM latency + 1; decode stall holds the head and throttles fetch via credits.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instruction,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   fetch_state_t   state;
   logic [31:0]    pc;
   logic [31:0]    rsp_pc;
   logic [CW-1:0]  inflight;
   logic [CW-1:0]  inflight_next;
   logic [CW-1:0]  drop;
   logic [CW-1:0]  drop_next;
   logic [CW-1:0]  q_count;
   logic           q_empty;
   logic           q_full;
   logic           q_push;
   logic           q_pop;
   logic           req_fire;
   logic           credit_ok;
   fetch_entry_t   push_entry;
   fetch_entry_t   head;

   assign credit_ok      = (int'(inflight) + int'(q_count)) < QUEUE_DEPTH;
   assign imem_req_valid = !rst && (state != S_IDLE) && !redirect_valid && credit_ok;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

   // Live responses are always sequential from the last redirect target, so one
   // running PC tags them; no per-request address queue is needed.
   assign q_push          = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign push_entry.inst = imem_rsp_data;
   assign push_entry.pc   = rsp_pc;
   assign q_pop           = id_valid && id_ready;

   always_comb begin
      drop_next = drop;
      if (redirect_valid) begin
         drop_next = inflight_next;
      end else if (imem_rsp_valid && (drop != '0)) begin
         drop_next = drop - CW'(1);
      end
   end

   fetch_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (q_push),
      .pop      (q_pop),
      .flush    (redirect_valid),
      .push_dat (push_entry),
      .head_dat (head),
      .count    (q_count),
      .empty    (q_empty),
      .full     (q_full)
   );

   assign id_valid       = !rst && !q_empty;
   assign id_instruction = id_valid ? head.inst : RV32I_NOP_INST;
   assign id_pc          = id_valid ? head.pc : 32'h0;
   assign id_pc_plus4    = id_valid ? (head.pc + 32'd4) : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight_next;
         drop     <= drop_next;
         if (redirect_valid) begin
            pc     <= redirect_pc & ~32'd3;
            rsp_pc <= redirect_pc & ~32'd3;
         end else begin
            if (req_fire) pc     <= pc + 32'd4;
            if (q_push)   rsp_pc <= rsp_pc + 32'd4;
         end
         case (state)
            S_IDLE:  state <= S_FETCH;
            S_FETCH: if (redirect_valid && (inflight_next != '0)) state <= S_DRAIN;
            S_DRAIN: if (drop_next == '0) state <= S_FETCH;
            default: state <= S_IDLE;
         endcase
      end
   end

   a_credit: assert property (@(posedge clk) disable iff (rst)
      (int'(inflight) + int'(q_count)) <= QUEUE_DEPTH);
   a_drop: assert property (@(posedge clk) disable iff (rst) drop <= inflight);
   a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (inflight != '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (q_push && q_full) |-> q_pop);

endmodule

// File: tb/tb_fetch_stage.sv
// Random + directed bench for fetch_stage: IMEM model with in-order variable latency,
// scoreboard of the architectural fetch stream (sequential PCs restarting at each redirect/reset).
`timescale 1ns/1ps
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instruction;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;

   fetch_stage #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instruction (id_instruction),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_due = 0;
   int fires = 0;
   int p_idr = 100;
   int p_rdy = 100;
   int lat_lo = 1;
   int lat_hi = 1;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_next = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: expected event not seen within bound (cycle %0d)", name, cyc);
   endtask

   task automatic refill();
      while (exp_q.size() < 8) begin
         exp_q.push_back(exp_next);
         exp_next = exp_next + 32'd4;
      end
   endtask

   task automatic restart(input logic [31:0] base);
      exp_q.delete();
      exp_next = base & ~32'd3;
      refill();
   endtask

   task automatic tick_begin();
      @(posedge clk);
      #1;
      id_ready       = (int'($urandom_range(99)) < p_idr);
      imem_req_ready = (int'($urandom_range(99)) < p_rdy);
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   task automatic tick_end(input logic redir, input logic [31:0] rpc);
      int due;
      redirect_valid = redir;
      if (redir) begin
         redirect_pc = rpc;
         restart(rpc);
      end
      refill();
      #1;
      if (imem_req_valid && imem_req_ready) begin
         due = cyc + int'($urandom_range(lat_hi, lat_lo));
         if (due <= last_due) due = last_due + 1;
         pend_addr.push_back(imem_req_addr);
         pend_due.push_back(due);
         last_due = due;
         fires++;
      end
      cyc++;
   endtask

   task automatic tick();
      tick_begin();
      tick_end(1'b0, 32'h0);
   endtask

   // IMEM is reset together with the fetch stage, so outstanding words vanish.
   task automatic do_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         rst = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
         imem_req_ready = 1'b1; id_ready = 1'b1;
         pend_addr.delete(); pend_due.delete(); last_due = 0;
         #1;
         if (i == 1) begin
            check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
            check("rst_id_instruction", id_instruction, NOP);
         end
         cyc++;
      end
      @(posedge clk);
      #1;
      rst = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
      id_ready = (int'($urandom_range(99)) < p_idr);
      restart(RESET_PC);
      #1;
      check("idle_no_req", {31'h0, imem_req_valid}, 32'h0);
      cyc++;
      tick_begin();
      imem_req_ready = 1'b1;
      tick_end(1'b0, 32'h0);
      check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("first_req_addr", imem_req_addr, RESET_PC);
   endtask

   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_id_valid", {31'h0, id_valid}, 32'h0);
         check("rst_id_pc", id_pc, 32'h0);
         check("rst_id_pc_plus4", id_pc_plus4, 32'h0);
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && !redirect_valid) begin
            check("req_hold_valid", {31'h0, imem_req_valid}, 32'h1);
            check("req_hold_addr", imem_req_addr, prev_addr);
         end
         if (!redirect_valid) begin
            if (id_valid) begin
               if (exp_q.size() == 0) begin
                  fail_now("scoreboard_empty");
               end else begin
                  check("id_pc", id_pc, exp_q[0]);
                  check("id_instruction", id_instruction, mem_word(exp_q[0]));
                  check("id_pc_plus4", id_pc_plus4, exp_q[0] + 32'd4);
                  if (id_ready) void'(exp_q.pop_front());
               end
            end else begin
               check("empty_nop", id_instruction, NOP);
               check("empty_pc", id_pc, 32'h0);
            end
         end
         prev_hold = imem_req_valid && !imem_req_ready;
         prev_addr = imem_req_addr;
      end
   end

   initial begin
      logic found;
      int   r;

      // Latency 1, no stalls: first word at cycle 3, then 0x4.
      p_idr = 100; p_rdy = 100; lat_lo = 1; lat_hi = 1;
      do_reset();
      tick();
      check("t1_c2_valid", {31'h0, id_valid}, 32'h0);
      tick();
      check("t1_c3_valid", {31'h0, id_valid}, 32'h1);
      check("t1_c3_pc", id_pc, 32'h0);
      tick();
      check("t1_c4_pc", id_pc, 32'h4);
      repeat (10) tick();

      // Decode stalled: only the credit limit worth of requests goes out.
      p_idr = 0;
      fires = 0;
      do_reset();
      repeat (5) tick();
      check("t2_fires", fires, 2);
      check("t2_head_pc", id_pc, 32'h0);
      p_idr = 100;
      repeat (12) tick();

      // Two stale words in flight at latency 3 must be dropped.
      p_idr = 0; lat_lo = 3; lat_hi = 3;
      do_reset();
      for (int i = 0; i < 10 && pend_addr.size() < 2; i++) tick();
      check("t3_inflight", pend_addr.size(), 2);
      tick_begin();
      tick_end(1'b1, 32'h100);
      p_idr = 100;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (id_valid) begin
            found = 1'b1;
            check("t3_first_pc", id_pc, 32'h100);
            break;
         end
      end
      if (!found) fail_now("t3_target_seen");
      repeat (8) tick();

      // Redirect coinciding with a response while the queue holds a word.
      p_idr = 0; lat_lo = 1; lat_hi = 1;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick_begin();
         if (imem_rsp_valid && id_valid && pend_addr.size() == 0) begin
            found = 1'b1;
            tick_end(1'b1, 32'h100);
         end else begin
            tick_end(1'b0, 32'h0);
         end
      end
      if (!found) fail_now("t4_setup");
      tick();
      check("t4_flushed", {31'h0, id_valid}, 32'h0);
      check("t4_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("t4_req_addr", imem_req_addr, 32'h100);
      p_idr = 100;
      repeat (8) tick();

      // Misaligned target near the top of the address space wraps.
      tick_begin();
      tick_end(1'b1, 32'hFFFF_FFFE);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (id_valid) begin
            found = 1'b1;
            check("t5_pc", id_pc, 32'hFFFF_FFFC);
            check("t5_pc_plus4", id_pc_plus4, 32'h0);
            break;
         end
      end
      if (!found) fail_now("t5_wrap_seen");
      repeat (8) tick();

      // Reset in the middle of a drain.
      lat_lo = 4; lat_hi = 4;
      do_reset();
      tick_begin();
      tick_end(1'b1, 32'h200);
      do_reset();
      repeat (12) tick();

      // Randomised traffic.
      for (int blk = 0; blk < 20; blk++) begin
         p_idr  = int'($urandom_range(100));
         p_rdy  = int'($urandom_range(100, 20));
         lat_lo = int'($urandom_range(3, 1));
         lat_hi = lat_lo + int'($urandom_range(3));
         for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(999));
            if (r < 3) begin
               do_reset();
            end else begin
               tick_begin();
               if (r < 40) tick_end(1'b1, $urandom);
               else        tick_end(1'b0, 32'h0);
            end
         end
      end
      p_idr = 100;
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
